// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the MIPS core. Owns the program counter, issues one fetch
// request at a time to instruction memory, captures the returned word and
// holds it toward decode until decode consumes it. When decode consumes the
// held word it also supplies the redirect inputs (jump, branch_taken and the
// sign-extended immediate), and the fetch unit forms the next PC from them.
//
// Sequence per instruction: REQ -> WAIT -> HOLD -> REQ. There is no overlap,
// so one instruction takes at least three cycles.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising clk edge where the producer's valid and
//   the consumer's ready are both high. The producer keeps valid and its
//   payload stable until the transfer. The imem response channel has no
//   ready; a response is taken only in WAIT and is ignored in any other state.
//
// Parameters:
//   RESET_PC          PC loaded on reset (word aligned; bits [1:0] forced 0)
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   imem_req_valid    fetch request valid (high in REQ)
//   imem_req_ready    memory accepts the request
//   imem_addr         fetch address, always equal to the PC
//   imem_resp_valid   instruction word returned by memory
//   imem_resp_data    instruction word
//   instr_valid       instr / instr_pc / imm16 valid toward decode (HOLD)
//   instr_ready       decode consumes the held instruction this cycle
//   instr             held instruction word
//   instr_pc          PC of the held instruction
//   imm16             instr[15:0], sent to the sign extender
//   imm_ext           sign-extended imm16 returned by the sign extender
//   branch_taken      held branch resolved as taken
//   jump              held instruction is J/JAL
//   fetch_stall_cnt   (only with FETCH_PERF_CNT_EN) saturating count of
//                     cycles spent waiting on instruction memory
//
// Build option:
//   FETCH_PERF_CNT_EN  when defined, adds the fetch_stall_cnt port/counter.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [15:0] imm16,
    input  logic [31:0] imm_ext,
    input  logic        branch_taken,
    input  logic        jump
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // State and datapath registers.
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;

    // Next-PC datapath.
    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] next_pc;

    // -------------------------------------------------------------------------
    // Next-PC selection. Only meaningful in HOLD; it is used when decode
    // consumes the held instruction. Jump has priority over a taken branch.
    // -------------------------------------------------------------------------
    always_comb begin
        seq_pc     = instr_pc_q + 32'd4;
        // A 32-bit left shift drops imm_ext[31:30], which is the intended
        // {imm_ext[29:0], 2'b00} word offset.
        branch_off = imm_ext << 2;
        branch_pc  = seq_pc + branch_off;
        jump_pc    = {seq_pc[31:28], instr_q[25:0], 2'b00};
        if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end else begin
            next_pc = seq_pc;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and register updates.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        unique case (state_q)
            REQ: begin
                // imem_req_valid is high throughout REQ once out of reset.
                if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    instr_d    = imem_resp_data;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // Redirect inputs only matter in the consume cycle.
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC_ALIGNED;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The state register already reads REQ during reset, so the
    // request valid is qualified with rst_n to read low while reset is held.
    // -------------------------------------------------------------------------
    assign imem_req_valid = rst_n && (state_q == REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = rst_n && (state_q == HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign imm16          = instr_q[15:0];

`ifdef FETCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Stall counter: cycles the fetch unit waits on memory, either for the
    // request to be accepted or for the response to come back. Saturating.
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_cycle;

    always_comb begin
        stall_cycle = ((state_q == REQ)  && !imem_req_ready) ||
                      ((state_q == WAIT) && !imem_resp_valid);
        stall_cnt_d = stall_cnt_q;
        if (stall_cycle && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. Driver tasks play both instruction
// memory and decode; each fetch pushes its expected address and its expected
// {instruction, pc} into queues. A monitor on the falling edge pops and
// compares whenever a request is accepted or an instruction is presented.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [15:0] imm16;
  logic [31:0] imm_ext = 32'h0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .imm16           (imm16),
    .imm_ext         (imm_ext),
    .branch_taken    (branch_taken),
    .jump            (jump)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];   // {instr, instr_pc}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- monitor
  logic [63:0] mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
        else check("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end else if (imem_req_valid && exp_addr_q.size() != 0) begin
        check("addr_stable", imem_addr, exp_addr_q[0]);
      end
      if (instr_valid) begin
        if (exp_instr_q.size() == 0) begin
          check("unexpected_instr", 32'd1, 32'd0);
        end else begin
          mon_e = exp_instr_q[0];
          check("instr", instr, mon_e[63:32]);
          check("instr_pc", instr_pc, mon_e[31:0]);
          check("imm16", {16'h0, imm16}, {16'h0, mon_e[47:32]});
          if (instr_ready) void'(exp_instr_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // All driver tasks start and end 1 time unit after a rising edge.

  // Memory side: hold ready low for ready_low cycles, accept, then return the
  // word after resp_wait empty WAIT cycles. With spurious set, junk responses
  // are driven while the request is pending and in the accept cycle.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int ready_low, input int resp_wait, input bit spurious);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back({data, addr});
    imem_req_ready  = 1'b0;
    imem_resp_valid = spurious;
    imem_resp_data  = ~data;
    repeat (ready_low) begin
      @(posedge clk); #1;
      check("req_valid_held", {31'h0, imem_req_valid}, 32'd1);
    end
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    repeat (resp_wait) begin
      @(posedge clk); #1;
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    @(posedge clk); #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  // Decode side: stall for `stall` cycles (with junk redirect inputs, a junk
  // response and memory ready high, all of which must be ignored), then
  // consume with the given redirect inputs.
  task automatic do_hold(input int stall, input bit br, input bit jmp, input logic [31:0] ext);
    instr_ready = 1'b0;
    repeat (stall) begin
      branch_taken    = 1'b1;
      jump            = 1'b1;
      imm_ext         = 32'h0000_0400;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_BAD0;
      @(posedge clk); #1;
    end
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b1;
    branch_taken    = br;
    jump            = jmp;
    imm_ext         = ext;
    @(posedge clk); #1;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    imm_ext      = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'd0);
    check({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'd0);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
  endtask

  // Request accepted, then reset pulsed while waiting for the response.
  task automatic reset_in_wait(input logic [31:0] addr);
    exp_addr_q.push_back(addr);
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 50000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic fetch from RESET_PC, sequential.
    do_fetch(32'h0000_0000, 32'h2401_0005, 0, 0, 0);
    do_hold(0, 1'b0, 1'b0, 32'h0);
    // Ready low 5 cycles with spurious responses; decode stalls 4 cycles.
    do_fetch(32'h0000_0004, 32'h0000_8020, 5, 1, 1);
    do_hold(4, 1'b0, 1'b0, 32'h0);
    // J with target index 0x40 -> 0x100.
    do_fetch(32'h0000_0008, 32'h0800_0040, 0, 0, 0);
    do_hold(0, 1'b0, 1'b1, 32'h0);
    // Backward branch: 0x104 + (0xFFFF_FFFE << 2) = 0xFC.
    do_fetch(32'h0000_0100, 32'h1000_FFFE, 0, 2, 0);
    do_hold(0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    // Forward branch: 0x100 + 0x0FFF_FF00 = 0x1000_0000.
    do_fetch(32'h0000_00FC, 32'h1000_FFC0, 1, 0, 0);
    do_hold(1, 1'b1, 1'b0, 32'h03FF_FFC0);
    // Jump and branch together: jump wins -> 0x1000_0100.
    do_fetch(32'h1000_0000, 32'h0800_0040, 0, 0, 0);
    do_hold(0, 1'b1, 1'b1, 32'h0000_0010);
    // imm_ext[31:30] dropped: 0x1000_0104 + 0xEFFF_FEF8 = 0xFFFF_FFFC.
    do_fetch(32'h1000_0100, 32'h1000_FFBE, 0, 0, 0);
    do_hold(0, 1'b1, 1'b0, 32'hFBFF_FFBE);
    // Sequential wrap from 0xFFFF_FFFC to 0.
    do_fetch(32'hFFFF_FFFC, 32'h0123_4567, 0, 0, 0);
    do_hold(0, 1'b0, 1'b0, 32'h0);
    // imm_ext = -1: branch to seq-4 = 0.
    do_fetch(32'h0000_0000, 32'h1000_FFFF, 0, 0, 0);
    do_hold(0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    do_fetch(32'h0000_0000, 32'hDEAD_BEEF, 0, 1, 0);
    do_hold(0, 1'b0, 1'b0, 32'h0);
    // Reset during WAIT at 0x4; restart at RESET_PC.
    reset_in_wait(32'h0000_0004);
    do_fetch(RESET_PC, 32'hCAFE_F00D, 3, 2, 0);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", fetch_stall_cnt, 32'd5);
`endif
    do_hold(0, 1'b0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("exp_addr_q_empty", exp_addr_q.size(), 32'd0);
    check("exp_instr_q_empty", exp_instr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the MIPS core.
- Owns the PC register and runs a valid/ready request/response handshake with instruction memory.
- Holds the fetched word and presents it to decode, including the raw imm16 field that feeds the sign extender.
- Consumes the sign extender's 32-bit result back to form the branch target (PC+4 + (imm_ext<<2)). Also resolves jump targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  fetch address; equals pc.
- imem_resp_valid  input  1  instruction word returned.
- imem_resp_data  input  32  instruction word.
- instr_valid  output  1  instr/instr_pc/imm16 valid toward decode.
- instr_ready  input  1  decode consumes the instruction this cycle.
- instr  output  32  latched instruction.
- instr_pc  output  32  PC of the latched instruction.
- imm16  output  16  instr[15:0]; goes to the sign extender.
- imm_ext  input  32  sign-extended imm16 returned from the sign extender.
- branch_taken  input  1  decode/ALU resolved the held branch as taken.
- jump  input  1  held instruction is J/JAL.

Behaviour:
- State register fsm: REQ, WAIT, HOLD. Reset (rst_n=0, async) values:
  - fsm=REQ, pc=RESET_PC
  - instr=0, instr_pc=0, instr_valid=0, imem_req_valid=0
  - Release is synchronous to the next clk edge.
- imem_req_valid = (fsm==REQ); imem_addr = pc at all times.
- instr_valid = (fsm==HOLD); imm16 = instr[15:0] (combinational from the register).
- REQ: on imem_req_valid && imem_req_ready -> WAIT. Otherwise stay in REQ, keeping addr stable.
- WAIT: on imem_resp_valid -> instr<=imem_resp_data, instr_pc<=pc, go to HOLD. Zero-latency responses (resp in the same cycle as req accept) are not accepted; a response is only taken in WAIT.
- HOLD: instr/instr_pc held stable until instr_ready. On instr_ready:
  - pc <= next_pc, then -> REQ.
  - Redirect inputs are sampled only in this cycle.
- next_pc, where seq = instr_pc + 32'd4, all arithmetic mod 2^32:
  - jump=1: {seq[31:28], instr[25:0], 2'b00}.
  - else branch_taken=1: seq + {imm_ext[29:0], 2'b00}.
  - else: seq.
- Boundary conditions:
  - jump and branch_taken both asserted: jump wins.
  - PC 32'hFFFF_FFFC sequential: wraps to 32'h0000_0000.
  - Negative imm_ext (e.g. 32'hFFFF_FFFF): backward branch to seq-4.
  - imem_resp_valid in REQ or HOLD: ignored, with no state change.
  - branch_taken/jump outside HOLD+instr_ready: ignored.
- Throughput: minimum 3 cycles per instruction (REQ, WAIT, HOLD), with no overlap.
- Reset asserted mid-transaction: FSM returns to REQ at RESET_PC and any held instruction is discarded. Instruction memory shares rst_n, so no stale response exists after reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Extra output port fetch_stall_cnt (32 bits).
  - Increments every cycle fsm is REQ with !imem_req_ready, or WAIT with !imem_resp_valid.
  - Saturates at 32'hFFFF_FFFF; reset to 0 by rst_n.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Test Plan:
- Reset with RESET_PC=0, ready=1, resp one cycle after accept -> imem_addr=0x0. instr_valid rises 2 cycles after release with instr=resp data and instr_pc=0. With instr_ready=1, next imem_addr=0x4.
- HOLD with instr_pc=0x100, branch_taken=1, imm_ext=0xFFFF_FFFE -> next imem_addr = 0x104 - 8 = 0xFC.
- HOLD with instr_pc=0x1000_0000, jump=1, instr[25:0]=0x0000040, branch_taken=1 also high -> next addr 0x1000_0100 (jump priority).
- instr_pc=0xFFFF_FFFC, sequential -> next addr 0x0000_0000. Also imem_req_ready held low 5 cycles -> addr stable, req_valid high throughout, no advance.
- Spurious resp_valid in REQ, and instr_ready low for 4 cycles in HOLD -> instr/instr_pc unchanged, no extra fetch issued.
- rst_n pulsed low while in WAIT -> outputs immediately at reset values, restart at RESET_PC. With FETCH_PERF_CNT_EN: 3 ready-low cycles plus 2 resp-wait cycles -> fetch_stall_cnt=5.
